// File: rtl/read_ctrl_pkg.sv
// Shared types for the read controller: FSM state encoding and a width helper
// that keeps degenerate parameter values (1 channel, no timeout) at one bit.
package read_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    W_DONE = 2'd2
  } state_e;

  function automatic int safe_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or above ptr,
// wrapping to the lowest requester when nothing lies above ptr.
module rr_arbiter
  import read_ctrl_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]                 req,
  input  logic [safe_width(NCH)-1:0]     ptr,
  output logic [NCH-1:0]                 gnt,
  output logic                           valid
);

  logic [NCH-1:0] mask_hi;
  logic [NCH-1:0] req_hi;
  logic [NCH-1:0] pick;

  // Isolating the lowest set bit of the chosen half gives the one-hot grant.
  always_comb begin
    mask_hi = {NCH{1'b1}} << ptr;
    req_hi  = req & mask_hi;
    pick    = (|req_hi) ? req_hi : req;
    gnt     = pick & (~pick + NCH'(1));
    valid   = |req;
  end

endmodule

// File: rtl/read_control_mc.sv
// Multi-channel read controller: arbitrates level requests round-robin, issues
// one memory read at a time and returns a per-channel completion or timeout.
module read_control_mc
  import read_ctrl_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [NCH-1:0] RReadIn,
  input  logic           Done,
  output logic           RReadOut,
  output logic [NCH-1:0] Grant,
  output logic [NCH-1:0] DoneOut,
  output logic           Err,
  output logic           Busy
);

  localparam int PW = safe_width(NCH);
  localparam int CW = safe_width(TIMEOUT + 1);
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PW-1:0] PTR_LAST = PW'(NCH - 1);

  state_e         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0] blocked_q, blocked_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rread_q, rread_d;
  logic [NCH-1:0] grant_q, grant_d;
  logic [NCH-1:0] done_out_q, done_out_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;

  logic [NCH-1:0] eligible;
  logic [NCH-1:0] arb_gnt;
  logic           arb_valid;
  logic [PW-1:0]  gnt_idx;
  logic           complete;
  logic           timeout_hit;

  assign eligible = RReadIn & ~blocked_q;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (eligible),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (arb_gnt[i]) gnt_idx = PW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rread_d     = 1'b0;
    grant_d     = grant_q;
    done_out_d  = '0;
    err_d       = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = ISSUE;
          grant_d = arb_gnt;
          rread_d = 1'b1;
          ptr_d   = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PW'(1);
        end
      end
      ISSUE: begin
        if (Done) begin
          complete = 1'b1;
        end else begin
          state_d = W_DONE;
          cnt_d   = '0;
        end
      end
      W_DONE: begin
        // Done takes priority over a timeout landing on the same cycle.
        if (Done) begin
          complete = 1'b1;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          complete    = 1'b1;
          timeout_hit = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      state_d    = IDLE;
      grant_d    = '0;
      done_out_d = grant_q;
      err_d      = timeout_hit;
    end

    // A finished channel stays blocked until it lowers its request once.
    blocked_d = (complete ? grant_q : '0) | (blocked_q & RReadIn);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      blocked_q  <= '0;
      cnt_q      <= '0;
      rread_q    <= 1'b0;
      grant_q    <= '0;
      done_out_q <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      blocked_q  <= blocked_d;
      cnt_q      <= cnt_d;
      rread_q    <= rread_d;
      grant_q    <= grant_d;
      done_out_q <= done_out_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign RReadOut = rread_q;
  assign Grant    = grant_q;
  assign DoneOut  = done_out_q;
  assign Err      = err_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_read_control_mc.sv
// Directed bench for read_control_mc: single read, round robin, timeout,
// Done/timeout race, immediate Done and reset in the middle of a read.
module tb_read_control_mc;

  localparam int NCH     = 4;
  localparam int TIMEOUT = 8;

  logic           CLK = 1'b0;
  logic           RST;
  logic [NCH-1:0] RReadIn;
  logic           Done;
  logic           RReadOut;
  logic [NCH-1:0] Grant;
  logic [NCH-1:0] DoneOut;
  logic           Err;
  logic           Busy;

  int error_count = 0;
  int check_count = 0;
  int cycle_no    = 0;

  read_control_mc #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RReadIn  (RReadIn),
    .Done     (Done),
    .RReadOut (RReadOut),
    .Grant    (Grant),
    .DoneOut  (DoneOut),
    .Err      (Err),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] req, input logic done);
    RReadIn = req;
    Done    = done;
  endtask

  // Inputs change and outputs are observed on the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      cycle_no++;
    end
  endtask

  task automatic waitRead(input string tag, output int at_cycle);
    bit seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      if (RReadOut) seen = 1'b1;
      else step(1);
    end
    at_cycle = cycle_no;
    if (!seen) checkOutput({tag, "_wait_rread"}, 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] allOutputs();
    return {21'd0, RReadOut, Grant, DoneOut, Err, Busy};
  endfunction

  initial begin
    int at;
    int prev_at;
    int pulses;
    int n;
    logic [NCH-1:0] exp_g;

    RST = 1'b1;
    applyStimulus(4'b1111, 1'b0);
    step(2);
    checkOutput("reset_outputs", allOutputs(), 32'd0);
    applyStimulus(4'b0000, 1'b0);
    step(1);
    RST = 1'b0;
    step(1);

    // Single channel, Done three cycles after the read strobe.
    applyStimulus(4'b0001, 1'b0);
    step(1);
    checkOutput("single_rread", 32'(RReadOut), 32'd1);
    checkOutput("single_grant", 32'(Grant), 32'h1);
    checkOutput("single_busy", 32'(Busy), 32'd1);
    step(1);
    checkOutput("single_rread_1cyc", 32'(RReadOut), 32'd0);
    step(2);
    checkOutput("single_no_early_done", 32'(DoneOut), 32'd0);
    Done = 1'b1;
    step(1);
    checkOutput("single_doneout", 32'(DoneOut), 32'h1);
    checkOutput("single_err", 32'(Err), 32'd0);
    checkOutput("single_grant_clr", 32'(Grant), 32'd0);
    checkOutput("single_busy_clr", 32'(Busy), 32'd0);
    Done = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      pulses += int'(RReadOut);
    end
    checkOutput("single_no_reissue", 32'(pulses), 32'd0);
    applyStimulus(4'b0000, 1'b0);
    step(1);

    // Reset so round robin starts from pointer 0.
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    step(1);

    applyStimulus(4'b1111, 1'b0);
    step(1);
    prev_at = 0;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'(1 << (k % NCH));
      waitRead($sformatf("rr%0d", k), at);
      checkOutput($sformatf("rr_grant%0d", k), 32'(Grant), 32'(exp_g));
      if (k > 0) checkOutput($sformatf("rr_gap%0d", k), 32'(at - prev_at), 32'd2);
      prev_at = at;
      Done = 1'b1;
      step(1);
      checkOutput($sformatf("rr_doneout%0d", k), 32'(DoneOut), 32'(exp_g));
      Done = 1'b0;
      RReadIn = (k == 4) ? 4'b0000 : (4'b1111 & ~exp_g);
      step(1);
      if (k < 4) RReadIn = 4'b1111;
    end
    step(1);

    // Timeout: Done never arrives.
    applyStimulus(4'b0100, 1'b0);
    step(1);
    waitRead("to", at);
    checkOutput("to_grant", 32'(Grant), 32'h4);
    n = 0;
    while (DoneOut == '0 && n < 20) begin
      step(1);
      n++;
    end
    checkOutput("to_latency", 32'(n), 32'd9);
    checkOutput("to_doneout", 32'(DoneOut), 32'h4);
    checkOutput("to_err", 32'(Err), 32'd1);
    checkOutput("to_grant_clr", 32'(Grant), 32'd0);
    checkOutput("to_busy_clr", 32'(Busy), 32'd0);
    step(1);
    checkOutput("to_err_pulse", 32'(Err), 32'd0);
    checkOutput("to_no_reissue", 32'(RReadOut), 32'd0);
    applyStimulus(4'b0000, 1'b0);
    step(1);

    // Done in the eighth wait cycle beats the timeout.
    applyStimulus(4'b0100, 1'b0);
    step(1);
    waitRead("race", at);
    step(8);
    checkOutput("race_busy", 32'(Busy), 32'd1);
    Done = 1'b1;
    step(1);
    checkOutput("race_doneout", 32'(DoneOut), 32'h4);
    checkOutput("race_err", 32'(Err), 32'd0);
    applyStimulus(4'b0000, 1'b0);
    step(1);

    // Done during the issue cycle.
    applyStimulus(4'b1000, 1'b0);
    step(1);
    waitRead("imm", at);
    checkOutput("imm_grant", 32'(Grant), 32'h8);
    Done = 1'b1;
    step(1);
    checkOutput("imm_doneout", 32'(DoneOut), 32'h8);
    checkOutput("imm_err", 32'(Err), 32'd0);
    checkOutput("imm_busy", 32'(Busy), 32'd0);
    applyStimulus(4'b0000, 1'b0);
    step(1);

    // Reset while waiting for Done.
    applyStimulus(4'b0010, 1'b0);
    step(1);
    waitRead("rst", at);
    step(3);
    checkOutput("rst_busy_before", 32'(Busy), 32'd1);
    RST = 1'b1;
    #1;
    checkOutput("rst_outputs", allOutputs(), 32'd0);
    step(1);
    checkOutput("rst_held_outputs", allOutputs(), 32'd0);
    RST = 1'b0;
    step(1);
    checkOutput("rst_fresh_rread", 32'(RReadOut), 32'd1);
    checkOutput("rst_fresh_grant", 32'(Grant), 32'h2);
    checkOutput("rst_no_doneout", 32'(DoneOut), 32'd0);
    Done = 1'b1;
    step(1);
    checkOutput("rst_fresh_done", 32'(DoneOut), 32'h2);
    applyStimulus(4'b0000, 1'b0);
    step(2);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
